// File: rtl/rca_seq_addsub.sv
// Multicycle ripple-carry add/subtract unit: one SLICE-bit ripple stage reused
// over NSLICE cycles, carry held in a register between slices.
module rca_seq_addsub #(
   parameter int WIDTH = 32,
   parameter int SLICE = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   localparam int NSLICE = WIDTH / SLICE;
   localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

   generate
      if ((WIDTH % SLICE) != 0) begin : g_bad_slice
         $error("rca_seq_addsub: WIDTH must be a multiple of SLICE");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx_q;
   logic               carry_q;
   logic [WIDTH-1:0]   a_q, b_q;
   logic [SLICE-1:0]   a_slice, b_slice, slice_sum;
   logic               carry_out;
   logic [WIDTH-1:0]   sum_next;
   logic               last_slice;
   logic               accept;

   assign last_slice = (idx_q == IDX_W'(NSLICE - 1));
   assign accept     = in_valid && in_ready;

   // Select the operand slice addressed by the slice index.
   always_comb begin
      a_slice = '0;
      b_slice = '0;
      for (int s = 0; s < NSLICE; s++) begin
         if (idx_q == IDX_W'(s)) begin
            a_slice = a_q[s*SLICE +: SLICE];
            b_slice = b_q[s*SLICE +: SLICE];
         end
      end
   end

   always_comb begin : ripple_stage
      logic c;
      c         = carry_q;
      slice_sum = '0;
      for (int i = 0; i < SLICE; i++) begin
         slice_sum[i] = a_slice[i] ^ b_slice[i] ^ c;
         c            = (a_slice[i] & b_slice[i]) | (c & (a_slice[i] ^ b_slice[i]));
      end
      carry_out = c;
   end

   // Full sum as it will look once this slice is written; flags use it.
   always_comb begin
      sum_next = sum;
      for (int s = 0; s < NSLICE; s++) begin
         if (idx_q == IDX_W'(s)) begin
            sum_next[s*SLICE +: SLICE] = slice_sum;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_d = RUN;
         end
         RUN: begin
            if (last_slice) state_d = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Operand capture, per-slice accumulation and final flag update.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idx_q   <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         sum     <= '0;
         cout    <= 1'b0;
         ovf     <= 1'b0;
         zero    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  a_q     <= in1;
                  b_q     <= sub ? ~in2 : in2;
                  carry_q <= sub ? 1'b1 : cin;
                  idx_q   <= '0;
                  sum     <= '0;
               end
            end
            RUN: begin
               sum     <= sum_next;
               carry_q <= carry_out;
               if (last_slice) begin
                  idx_q <= '0;
                  cout  <= carry_out;
                  ovf   <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                           (sum_next[WIDTH-1] != a_q[WIDTH-1]);
                  zero  <= (sum_next == '0);
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_rca_seq_addsub.sv
// Self-checking bench for rca_seq_addsub: directed table, random ops against an
// arithmetic model, backpressure, mid-run reset and two alternate elaborations.
module tb_rca_seq_addsub;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid, in_ready, cin, sub, out_valid, out_ready;
   logic [31:0] in1, in2, sum;
   logic        cout, ovf, zero;

   logic        w_in_valid, w_in_ready, w_cin, w_sub, w_out_valid, w_out_ready;
   logic [31:0] w_in1, w_in2, w_sum;
   logic        w_cout, w_ovf, w_zero;

   logic        n_in_valid, n_in_ready, n_cin, n_sub, n_out_valid, n_out_ready;
   logic [15:0] n_in1, n_in2, n_sum;
   logic        n_cout, n_ovf, n_zero;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   rca_seq_addsub #(.WIDTH(32), .SLICE(8)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in1(in1), .in2(in2), .cin(cin), .sub(sub), .out_valid(out_valid),
      .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf), .zero(zero));

   rca_seq_addsub #(.WIDTH(32), .SLICE(32)) dut_w (
      .clk(clk), .reset(reset), .in_valid(w_in_valid), .in_ready(w_in_ready),
      .in1(w_in1), .in2(w_in2), .cin(w_cin), .sub(w_sub), .out_valid(w_out_valid),
      .out_ready(w_out_ready), .sum(w_sum), .cout(w_cout), .ovf(w_ovf), .zero(w_zero));

   rca_seq_addsub #(.WIDTH(16), .SLICE(4)) dut_n (
      .clk(clk), .reset(reset), .in_valid(n_in_valid), .in_ready(n_in_ready),
      .in1(n_in1), .in2(n_in2), .cin(n_cin), .sub(n_sub), .out_valid(n_out_valid),
      .out_ready(n_out_ready), .sum(n_sum), .cout(n_cout), .ovf(n_ovf), .zero(n_zero));

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        c;
      logic        s;
      logic [31:0] esum;
      logic        ecout;
      logic        eovf;
      logic        ezero;
   } vec_t;

   vec_t vecs[7];

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the operands as unsigned and signed values.
   function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b,
                                         input logic c, input logic s);
      logic [63:0] ua, ub, u;
      longint      sa, sb, sr;
      logic        co, ov;
      ua = {32'b0, a};
      ub = {32'b0, b};
      sa = $signed(a);
      sb = $signed(b);
      if (!s) begin
         u  = ua + ub + {63'b0, c};
         co = u[32];
         sr = sa + sb + longint'(c);
      end else begin
         u  = ua - ub;
         co = (a >= b);
         sr = sa - sb;
      end
      ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      return {u[31:0], co, ov, (u[31:0] == 32'b0)};
   endfunction

   task automatic waitValid(output int n);
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!out_valid && n < 20);
   endtask

   // One full transaction on the main DUT with latency, result and handoff checks.
   task automatic applyStimulus(input string tag, input logic [31:0] a, input logic [31:0] b,
                                input logic c, input logic s, input logic [31:0] esum,
                                input logic ecout, input logic eovf, input logic ezero);
      int n;
      @(negedge clk);
      in1 = a; in2 = b; cin = c; sub = s; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in1 = $urandom; in2 = $urandom; cin = 1'($urandom); sub = 1'($urandom);
      checkOutput({tag, " in_ready_run"}, 64'(in_ready), 64'd0);
      waitValid(n);
      checkOutput({tag, " latency"}, 64'(n), 64'd4);
      checkOutput({tag, " sum"}, 64'(sum), 64'(esum));
      checkOutput({tag, " flags"}, {61'b0, cout, ovf, zero}, {61'b0, ecout, eovf, ezero});
      checkOutput({tag, " in_ready_done"}, 64'(in_ready), 64'd0);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      checkOutput({tag, " handoff"}, {62'b0, out_valid, in_ready}, 64'b01);
      checkOutput({tag, " hold"}, 64'(sum), 64'(esum));
   endtask

   initial begin
      int n;
      logic [34:0] m;
      logic [31:0] ra, rb;
      logic rc, rs;

      vecs[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
      vecs[1] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
      vecs[2] = '{32'h12345678, 32'h11111111, 1'b1, 1'b0, 32'h2345678A, 1'b0, 1'b0, 1'b0};
      vecs[3] = '{32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
      vecs[4] = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
      vecs[5] = '{32'h00000005, 32'h00000005, 1'b1, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};
      vecs[6] = '{32'h00000000, 32'h00000000, 1'b1, 1'b0, 32'h00000001, 1'b0, 1'b0, 1'b0};

      reset = 1'b1;
      in_valid = 0; out_ready = 0; in1 = 0; in2 = 0; cin = 0; sub = 0;
      w_in_valid = 0; w_out_ready = 0; w_in1 = 0; w_in2 = 0; w_cin = 0; w_sub = 0;
      n_in_valid = 0; n_out_ready = 0; n_in1 = 0; n_in2 = 0; n_cin = 0; n_sub = 0;
      #2;
      checkOutput("reset_state", {29'b0, sum, in_ready, out_valid, cout, ovf, zero},
                  {29'b0, 32'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 7; i++)
         applyStimulus($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].s,
                       vecs[i].esum, vecs[i].ecout, vecs[i].eovf, vecs[i].ezero);

      for (int i = 0; i < 40; i++) begin
         ra = $urandom; rb = $urandom; rc = 1'($urandom); rs = 1'($urandom);
         if (i % 8 == 0) ra = 32'h80000000;
         if (i % 8 == 1) rb = 32'hFFFFFFFF;
         if (i % 8 == 2) rb = ra;
         m = model(ra, rb, rc, rs);
         applyStimulus($sformatf("rnd%0d", i), ra, rb, rc, rs, m[34:3], m[2], m[1], m[0]);
      end

      // Backpressure with a second request held pending through DONE.
      @(negedge clk);
      in1 = 32'h10; in2 = 32'h20; cin = 0; sub = 0; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      waitValid(n);
      checkOutput("bp latency", 64'(n), 64'd4);
      @(negedge clk);
      in1 = 32'h100; in2 = 32'h1; cin = 0; sub = 0; in_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         checkOutput($sformatf("bp stall%0d", k), {29'b0, sum, out_valid, in_ready, cout, ovf, zero},
                     {29'b0, 32'h30, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      checkOutput("bp handoff", {62'b0, out_valid, in_ready}, 64'b01);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      checkOutput("bp accept", 64'(in_ready), 64'd0);
      waitValid(n);
      checkOutput("bp2 latency", 64'(n), 64'd4);
      checkOutput("bp2 sum", 64'(sum), 64'h101);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;

      // Asynchronous reset in the middle of the second RUN cycle.
      @(negedge clk);
      in1 = 32'h09090909; in2 = 32'h09090909; cin = 0; sub = 0; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      checkOutput("rst abort", {29'b0, sum, in_ready, out_valid, cout, ovf, zero},
                  {29'b0, 32'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("rst release", {62'b0, in_ready, out_valid}, 64'b10);
      applyStimulus("post_rst", 32'd3, 32'd4, 1'b0, 1'b0, 32'd7, 1'b0, 1'b0, 1'b0);

      // Single-slice elaboration: one-cycle latency.
      @(negedge clk);
      w_in1 = 32'hFFFFFFFF; w_in2 = 32'h0; w_cin = 1'b1; w_sub = 1'b0; w_in_valid = 1'b1;
      @(posedge clk);
      #1;
      w_in_valid = 1'b0;
      checkOutput("w run", 64'(w_out_valid), 64'd0);
      @(posedge clk);
      #1;
      checkOutput("w result", {29'b0, w_sum, w_out_valid, w_cout, w_ovf, w_zero},
                  {29'b0, 32'b0, 1'b1, 1'b1, 1'b0, 1'b1});
      @(negedge clk);
      w_out_ready = 1'b1;
      @(posedge clk);
      #1;
      w_out_ready = 1'b0;
      checkOutput("w handoff", {62'b0, w_out_valid, w_in_ready}, 64'b01);

      // 16-bit, 4-bit-slice elaboration.
      @(negedge clk);
      n_in1 = 16'h8000; n_in2 = 16'h8000; n_cin = 1'b0; n_sub = 1'b0; n_in_valid = 1'b1;
      @(posedge clk);
      #1;
      n_in_valid = 1'b0;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!n_out_valid && n < 20);
      checkOutput("n latency", 64'(n), 64'd4);
      checkOutput("n result", {45'b0, n_sum, n_cout, n_ovf, n_zero},
                  {45'b0, 16'h0, 1'b1, 1'b1, 1'b1});

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
